// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   md_op_t    : operation select encodings driven by control on op_sel
//   md_state_t : sequencer states (IDLE -> RUN -> FIX -> IDLE)
//   MD_ITER    : radix-2 iterations needed for a 32-bit operand
//   is_signed_op / is_mult_op / is_div_op : op_sel decode helpers
package mips_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int MD_ITER = 32;

    function automatic logic is_signed_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_mult_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration shared by multiply and divide.
//   is_div   in   1        0: shift-add multiply step, 1: restoring divide step
//   acc      in   2*WIDTH  multiply: {partial product, unconsumed multiplier}
//                          divide:   {partial remainder, unconsumed dividend / quotient}
//   operand  in   WIDTH    multiplicand or divisor magnitude
//   acc_next out  2*WIDTH  accumulator after this step (quotient bit position left 0)
//   q_bit    out  1        quotient bit produced by a divide step (0 for multiply)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Single step: add-then-shift-right for multiply, shift-then-trial-subtract for divide.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // acc[2W-1:W-1] is the remainder already shifted left with the next dividend bit appended.
        diff_s   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {sum_s, acc[WIDTH-1:1]};
        if (is_div) begin
            q_bit = ~diff_s[WIDTH];
            if (q_bit) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit.
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op_sel      launch an operation (ignored while busy)
//   rs_data, rt_data   operand A (multiplicand/dividend/MTxx source), operand B
//   abort              cancel the in-flight operation; HI/LO untouched
//   busy               operation in flight (state != IDLE)
//   done, div_zero     one-cycle pulses in the first IDLE cycle after FIX
//   hi, lo             HI and LO registers
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle
// array multiply and go straight to FIX; division stays iterative.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               dz_out_r;

    md_op_t             op_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic               step_q_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    assign op_s = md_op_t'(op_sel);

    // Operand magnitudes and sign flags captured on the start edge.
    always_comb begin
        a_neg_s = is_signed_op(op_s) & rs_data[WIDTH-1];
        b_neg_s = is_signed_op(op_s) & rt_data[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - rs_data) : rs_data;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - rt_data) : rt_data;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (step_acc_s),
        .q_bit    (step_q_s)
    );

    // Sign correction of the finished magnitude result; INT_MIN/-1 wraps back to INT_MIN naturally.
    always_comb begin
        prod_s   = neg_res_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        quot_s   = neg_res_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_s    = neg_rem_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (dz_r) begin
            // Divide by zero keeps the raw dividend in the low half of acc_r.
            fix_hi_s = acc_r[WIDTH-1:0];
            fix_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quot_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer, iteration datapath and HI/LO registers; abort overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            dz_out_r  <= 1'b0;
        end else if (abort) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
            dz_out_r <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            dz_out_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        case (op_s)
                            MD_MTHI: hi_r <= rs_data;
                            MD_MTLO: lo_r <= rs_data;
                            MD_MULT, MD_MULTU: begin
                                is_div_r  <= 1'b0;
                                dz_r      <= 1'b0;
                                neg_res_r <= a_neg_s ^ b_neg_s;
                                neg_rem_r <= 1'b0;
                                cnt_r     <= {CNT_W{1'b0}};
`ifdef MULDIV_FAST_MULT_EN
                                acc_r     <= {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
                                opnd_r    <= a_mag_s;
                                state_r   <= FIX;
`else
                                acc_r     <= {{WIDTH{1'b0}}, b_mag_s};
                                opnd_r    <= a_mag_s;
                                state_r   <= RUN;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                is_div_r  <= 1'b1;
                                neg_res_r <= a_neg_s ^ b_neg_s;
                                neg_rem_r <= a_neg_s;
                                opnd_r    <= b_mag_s;
                                cnt_r     <= {CNT_W{1'b0}};
                                if (rt_data == {WIDTH{1'b0}}) begin
                                    dz_r    <= 1'b1;
                                    acc_r   <= {{WIDTH{1'b0}}, rs_data};
                                    state_r <= FIX;
                                end else begin
                                    dz_r    <= 1'b0;
                                    acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                                    state_r <= RUN;
                                end
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                RUN: begin
                    acc_r <= step_acc_s | {{(2*WIDTH-1){1'b0}}, step_q_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    hi_r     <= fix_hi_s;
                    lo_r     <= fix_lo_s;
                    done_r   <= 1'b1;
                    dz_out_r <= dz_r;
                    cnt_r    <= {CNT_W{1'b0}};
                    state_r  <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign div_zero = dz_out_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand sequences for MTHI/MTLO,
// start-while-busy, abort and reset during an operation.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sel   (op_sel),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model straight from the ISA definition of each op.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edz, output int elat);
        logic [63:0] p;
        longint sa, sb, q, r;
        edz  = 1'b0;
        elat = 33;
        ehi  = 32'd0;
        elo  = 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; ehi = p[63:32]; elo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    edz = 1'b1; elat = 1; ehi = a; elo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    p = q; elo = p[31:0];
                    p = r; ehi = p[31:0];
                end else begin
                    elo = a / b; ehi = a % b;
                end
            end
            default: ;
        endcase
`ifdef MULDIV_FAST_MULT_EN
        if (op == 3'd0 || op == 3'd1) elat = 1;
`endif
    endfunction

    // Launch one op and wait (bounded) for done; lat = edges after the start edge, -1 on timeout.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; op_sel = op; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            chk("done_busy_excl", {63'd0, done & busy}, 64'd0);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        logic edz;
        int elat, lat;
        model(op, a, b, ehi, elo, edz, elat);
        do_op(op, a, b, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, edz});
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int lat;

        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'd7,         32'd3,         32'h2492_4924, 1'b0};
        vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};

        rst_n = 1'b0; start = 1'b0; op_sel = 3'd0; rs_data = 32'd0; rt_data = 32'd0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        rst_n = 1'b1;

        // Directed table: expected values written from hand arithmetic.
        for (int i = 0; i < 9; i++) begin
            int elat;
            elat = vecs[i].dz ? 1 : 33;
`ifdef MULDIV_FAST_MULT_EN
            if (vecs[i].op <= 3'd1) elat = 1;
`endif
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(elat));
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d_dz", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_1cyc", i), {62'd0, done, busy}, 64'd0);
        end

        // Randomized ops against the reference model, with biased corner operands.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
        end

        // MTHI then MTLO on consecutive edges.
        @(negedge clk);
        start = 1'b1; op_sel = 3'd4; rs_data = 32'h0000_1234;
        @(negedge clk);
        op_sel = 3'd5; rs_data = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mtlo_lo", {32'd0, lo}, 64'h5678);
        chk("mt_no_done", {62'd0, done, busy}, 64'd0);

        // abort with start in IDLE drops the start.
        start = 1'b1; op_sel = 3'd4; rs_data = 32'hDEAD_BEEF; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_idle_hi", {32'd0, hi}, 64'h1234);
        chk("abort_idle_busy", {63'd0, busy}, 64'd0);

        // DIVU in flight, ignored second start at cycle 5, abort at cycle 10.
        start = 1'b1; op_sel = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("abort_seq_busy", {63'd0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        start = 1'b1; op_sel = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("second_start_busy", {63'd0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy_low", {63'd0, busy}, 64'd0);
        begin
            int seen_done;
            seen_done = 0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                if (done || busy) seen_done++;
            end
            chk("abort_no_done", 64'(seen_done), 64'd0);
        end
        chk("abort_hi_kept", {32'd0, hi}, 64'h1234);
        chk("abort_lo_kept", {32'd0, lo}, 64'h5678);

        // Fresh op after abort uses its own operands.
        run_check("post_abort", 3'd1, 32'h0001_0000, 32'h0003_0000);

        // Reset mid-DIV clears immediately and discards the result.
        @(negedge clk);
        start = 1'b1; op_sel = 3'd2; rs_data = 32'd1000; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_busy", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("midrst_discarded", 64'(seen), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
